// File: rtl/hazard_pkg.sv
// Shared encodings and width helper for the pipeline hazard controller.
// The forwarding select values match the E-stage operand mux inputs.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Bits needed to hold the values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/long_op_scoreboard.sv
// Pending-register scoreboard and outstanding-operation counter for the
// multi-cycle mul/div unit, with three effective-pending read ports.
module long_op_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int LONG_DEPTH = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             mulDivE,
  input  logic [REG_W-1:0] writeRegE,
  input  logic             longDoneW,
  input  logic             regWriteW,
  input  logic [REG_W-1:0] writeRegW,
  input  logic [REG_W-1:0] rsAddr,
  input  logic [REG_W-1:0] rtAddr,
  input  logic [REG_W-1:0] wrAddr,
  output logic             rsPend,
  output logic             rtPend,
  output logic             wrPend,
  output logic             depthFull,
  output logic             longBusy
);

  localparam int NREG  = 1 << REG_W;
  localparam int CNT_W = clog2(LONG_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LONG_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(LONG_DEPTH);

  logic [NREG-1:0]  pend;
  logic [NREG-1:0]  pendNext;
  logic [NREG-1:0]  issueHot;
  logic [NREG-1:0]  effPend;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             issue;
  logic             done;

  assign issue = mulDivE & (writeRegE != '0);
  assign done  = longDoneW & regWriteW & (writeRegW != '0);

  // The set is applied after the clear so a same-register collision stays pending.
  always_comb begin
    pendNext = pend;
    if (done)  pendNext[writeRegW] = 1'b0;
    if (issue) pendNext[writeRegE] = 1'b1;
  end

  always_comb begin
    cntNext = cnt;
    if (mulDivE && !longDoneW && (cnt != CNT_MAX))
      cntNext = cnt + CNT_W'(1);
    else if (!mulDivE && longDoneW && (cnt != '0))
      cntNext = cnt - CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= pendNext;
      cnt  <= cntNext;
    end
  end

  // The op sitting in E is not yet registered, so it is folded in here.
  assign issueHot = mulDivE ? (NREG'(1) << writeRegE) : '0;
  assign effPend  = pend | issueHot;

  assign rsPend = (rsAddr != '0) & effPend[rsAddr];
  assign rtPend = (rtAddr != '0) & effPend[rtAddr];
  assign wrPend = (wrAddr != '0) & effPend[wrAddr];

  assign depthFull = (({1'b0, cnt} + (CNT_W + 1)'(mulDivE)) >= DEPTH_EXT);
  assign longBusy  = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding, load-use and long-op
// stalls, and a configurable-length flush window after a taken branch.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int LONG_DEPTH = 2,
  parameter int FLUSH_LEN  = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] WriteRegD,
  input  logic             UseRsD,
  input  logic             UseRtD,
  input  logic             RegWriteD,
  input  logic             MulDivD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic             MemtoRegE,
  input  logic             MulDivE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LongDoneW,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             LongBusy
);

  localparam int FCNT_W = clog2(FLUSH_LEN);

  logic              rsPend;
  logic              rtPend;
  logic              wrPend;
  logic              depthFull;
  logic              lwStall;
  logic              longStall;
  logic              flushing;
  logic [FCNT_W-1:0] fcnt;

  long_op_scoreboard #(
    .REG_W      (REG_W),
    .LONG_DEPTH (LONG_DEPTH)
  ) scoreboard (
    .CLK       (CLK),
    .CLR       (CLR),
    .mulDivE   (MulDivE),
    .writeRegE (WriteRegE),
    .longDoneW (LongDoneW),
    .regWriteW (RegWriteW),
    .writeRegW (WriteRegW),
    .rsAddr    (RsD),
    .rtAddr    (RtD),
    .wrAddr    (WriteRegD),
    .rsPend    (rsPend),
    .rtPend    (rtPend),
    .wrPend    (wrPend),
    .depthFull (depthFull),
    .longBusy  (LongBusy)
  );

  // The M stage holds the younger result, so it wins over W.
  function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (RegWriteM && (WriteRegM == src))      sel = FWD_M;
      else if (RegWriteW && (WriteRegW == src)) sel = FWD_W;
    end
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwdSel(RsE);
    ForwardBE = fwdSel(RtE);
  end

  assign lwStall = MemtoRegE & (RtE != '0) &
                   ((UseRsD & (RsD == RtE)) | (UseRtD & (RtD == RtE)));

  assign longStall = (UseRsD & rsPend) | (UseRtD & rtPend) |
                     (RegWriteD & wrPend) | (MulDivD & depthFull);

  // The cycle PCSrcE is high counts as the first flush cycle.
  generate
    if (FLUSH_LEN > 1) begin : gFlushCnt
      always_ff @(posedge CLK or posedge CLR) begin
        if (CLR)
          fcnt <= '0;
        else if (PCSrcE)
          fcnt <= FCNT_W'(FLUSH_LEN - 1);
        else if (fcnt != '0)
          fcnt <= fcnt - FCNT_W'(1);
      end
    end else begin : gNoFlushCnt
      assign fcnt = '0;
    end
  endgenerate

  assign flushing = PCSrcE | (fcnt != '0);

  assign StallF = (lwStall | longStall) & ~flushing;
  assign StallD = StallF;
  assign FlushE = flushing | lwStall | longStall;
  assign FlushD = PCSrcE;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS32 core, sitting beside the D/E/M/W pipeline registers. It supersedes the fixed forwarding/load-use logic: it qualifies every check against register 0, adds a register scoreboard for a multi-cycle mul/div unit with a configurable number of outstanding operations, and replaces the hard-wired two-cycle branch flush with a counter of configurable length.

## Interface
- REG_W, 5: register-address width; the register file has 2^REG_W entries.
- LONG_DEPTH, 2: maximum outstanding long (mul/div) operations, range 1..7.
- FLUSH_LEN, 2: cycles FlushE stays high per taken branch, range 1..8.

- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  asynchronous, active-high reset.
- RsD, RtD, WriteRegD  in  REG_W  D-stage source and destination registers.
- UseRsD, UseRtD, RegWriteD, MulDivD  in  1  D-stage qualifiers: source read, register write, long op.
- RsE, RtE, WriteRegE  in  REG_W  E-stage sources and destination.
- MemtoRegE, MulDivE  in  1  E-stage load, and long op issuing this cycle.
- WriteRegM, WriteRegW  in  REG_W  M/W destinations.
- RegWriteM, RegWriteW  in  1  M/W write enables.
- LongDoneW  in  1  the W-stage write is a long-op completion to WriteRegW.
- PCSrcE  in  1  branch/jump taken, resolved in E.
- StallF, StallD, FlushD, FlushE  out  1  pipeline control.
- ForwardAE, ForwardBE  out  2  E-operand select: 00 register file, 01 W, 10 M.
- LongBusy  out  1  at least one long op outstanding.

## Operation
- Forwarding: source X in {RsE, RtE}, X≠0. Select M if RegWriteM & WriteRegM==X, else W if RegWriteW & WriteRegW==X, else 00. M has priority.
- Load-use: lwstall = MemtoRegE & RtE≠0 & ((UseRsD & RsD==RtE) | (UseRtD & RtD==RtE)).
- Scoreboard: pend[2^REG_W], cnt[0..LONG_DEPTH].
  - issue = MulDivE & WriteRegE≠0 sets pend[WriteRegE].
  - done = LongDoneW & RegWriteW & WriteRegW≠0 clears pend[WriteRegW]. If set and clear hit the same register in one cycle, set wins.
  - cnt increments on MulDivE and decrements on LongDoneW. Both together leave it unchanged. It saturates at 0 and at LONG_DEPTH.
  - Effective pending is pend plus the one-hot of WriteRegE when MulDivE is high. It covers the op currently in E.
- longstall (all checks exclude register 0):
  - UseRsD and RsD is effectively pending;
  - UseRtD and RtD is effectively pending;
  - RegWriteD and WriteRegD is effectively pending (WAW);
  - MulDivD and cnt + MulDivE ≥ LONG_DEPTH.
- Branch flush: PCSrcE loads fcnt with FLUSH_LEN−1; fcnt then decrements to 0. flushing = PCSrcE | fcnt≠0.
- Outputs:
  - StallF = StallD = (lwstall | longstall) & ~flushing. Stalls are suppressed on the wrong path.
  - FlushE = flushing | lwstall | longstall.
  - FlushD = PCSrcE.
  - LongBusy = cnt≠0.

## Timing
- All outputs are combinational from inputs and state; there is no output register.
- Reset clears pend, cnt and fcnt to 0. With all inputs low, every output is 0 during and after reset.
- Reset mid-operation drops outstanding scoreboard entries. Software or the surrounding logic must also reset the long unit.
- Scoreboard and counter updates become visible the cycle after the edge. Same-cycle coverage comes from the MulDivE bypass term.
- A PCSrcE arriving while fcnt≠0 reloads fcnt; the window restarts.
- With FLUSH_LEN=1 the block holds no flush state; FlushE follows PCSrcE.

## Structure
- Package hazard_pkg holds the FWD_RF/FWD_W/FWD_M encodings and the clog2 helper used for the cnt and fcnt widths.
- Sub-module long_op_scoreboard holds pend, cnt, the set/clear rules and the effective-pending lookup for three read ports. The top level holds forwarding, lwstall, fcnt and output combination.

## Test plan
- Forwarding priority:
  - RsE=RtE=3, RegWriteM=RegWriteW=1, WriteRegM=WriteRegW=3 → ForwardAE=ForwardBE=10.
  - Same stimulus with RsE=RtE=0 → 00.
- Load-use:
  - MemtoRegE=1, RtE=5, RsD=5, UseRsD=1 → StallF=StallD=FlushE=1 for exactly one cycle.
  - Same with UseRsD=0 → no stall.
  - Same with RtE=0 → no stall.
- Long RAW:
  - MulDivE=1, WriteRegE=8, next cycle RsD=8 with UseRsD=1 → StallD held high until LongDoneW with WriteRegW=8.
  - StallD low the following cycle.
  - LongBusy falls when cnt returns to 0.
- Depth limit, LONG_DEPTH=2: two issues to regs 9 and 10, then MulDivD=1 → stall. One LongDoneW → stall released next cycle.
- Branch flush:
  - FLUSH_LEN=3, PCSrcE pulse → FlushE high 3 cycles, FlushD high 1 cycle.
  - Simultaneous lwstall → StallF=0.
  - Second PCSrcE in cycle 2 → FlushE high through cycle 4.
- Reset: assert CLR with pend and cnt nonzero → LongBusy=0 immediately (asynchronous), no stall after release.
